// File: rtl/ram_prog_loader.sv
// Streams bytes into the SAP RAM by sequencing the MAR load and RAM write pins.
// Define RAM_LOADER_VERIFY_EN to add a readback check after every write.
module ram_prog_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned LAST_ADDR  = (2**ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_drive,
  output logic                  load_mar_reg_n,
  output logic                  write_enable,
  output logic                  prog_mode,
  output logic                  addr_select,
  output logic                  bus_enable_n,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  if (START_ADDR > LAST_ADDR) begin : g_bad_cfg
    $error("ram_prog_loader: START_ADDR must not exceed LAST_ADDR");
  end

  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LMAR = 3'd2,
    S_WR   = 3'd3,
    S_VCHK = 3'd4,
    S_NEXT = 3'd5,
    S_DONE = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   byte_q, byte_d;
  logic                    error_q, error_d;

  logic                    byte_ready_q, byte_ready_d;
  logic [DATA_WIDTH-1:0]   bus_out_q, bus_out_d;
  logic                    bus_drive_q, bus_drive_d;
  logic                    load_mar_n_q, load_mar_n_d;
  logic                    we_q, we_d;
  logic                    prog_mode_q, prog_mode_d;
  logic                    addr_select_q, addr_select_d;
  logic                    bus_en_n_q, bus_en_n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

`ifndef RAM_LOADER_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  // Sequencer next-state, address walk and sticky verify flag
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    error_d = error_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT;
          addr_d  = START_A;
          error_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_WAIT: begin
        if (byte_valid) begin
          byte_d  = byte_in;
          state_d = S_LMAR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_LMAR: state_d = S_WR;
`ifdef RAM_LOADER_VERIFY_EN
      S_WR:   state_d = S_VCHK;
      S_VCHK: begin
        if (ram_rdata != byte_q) begin
          error_d = 1'b1;
        end else begin
          error_d = error_q;
        end
        state_d = S_NEXT;
      end
`else
      S_WR:   state_d = S_NEXT;
      S_VCHK: state_d = S_IDLE;
`endif
      S_NEXT: begin
        if (addr_q == LAST_A) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ONE_A;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifndef RAM_LOADER_VERIFY_EN
    error_d = 1'b0;
`endif
  end

  // Outputs are decoded from the next state so the pins come straight from flops
  always_comb begin
    byte_ready_d  = 1'b0;
    bus_out_d     = {DATA_WIDTH{1'b0}};
    bus_drive_d   = 1'b0;
    load_mar_n_d  = 1'b1;
    we_d          = 1'b0;
    addr_select_d = 1'b0;
    bus_en_n_d    = 1'b1;
    case (state_d)
      S_WAIT: byte_ready_d = 1'b1;
      S_LMAR: begin
        bus_out_d     = DATA_WIDTH'(addr_d);
        bus_drive_d   = 1'b1;
        addr_select_d = 1'b1;
        load_mar_n_d  = 1'b0;
      end
      S_WR: begin
        bus_out_d   = byte_d;
        bus_drive_d = 1'b1;
        we_d        = 1'b1;
      end
`ifdef RAM_LOADER_VERIFY_EN
      S_VCHK: bus_en_n_d = 1'b0;
`endif
      default: bus_en_n_d = 1'b1;
    endcase
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    prog_mode_d = busy_d;
    done_d      = (state_d == S_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= S_IDLE;
      addr_q        <= START_A;
      byte_q        <= {DATA_WIDTH{1'b0}};
      error_q       <= 1'b0;
      byte_ready_q  <= 1'b0;
      bus_out_q     <= {DATA_WIDTH{1'b0}};
      bus_drive_q   <= 1'b0;
      load_mar_n_q  <= 1'b1;
      we_q          <= 1'b0;
      prog_mode_q   <= 1'b0;
      addr_select_q <= 1'b0;
      bus_en_n_q    <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      byte_q        <= byte_d;
      error_q       <= error_d;
      byte_ready_q  <= byte_ready_d;
      bus_out_q     <= bus_out_d;
      bus_drive_q   <= bus_drive_d;
      load_mar_n_q  <= load_mar_n_d;
      we_q          <= we_d;
      prog_mode_q   <= prog_mode_d;
      addr_select_q <= addr_select_d;
      bus_en_n_q    <= bus_en_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign byte_ready     = byte_ready_q;
  assign bus_out        = bus_out_q;
  assign bus_drive      = bus_drive_q;
  assign load_mar_reg_n = load_mar_n_q;
  assign write_enable   = we_q;
  assign prog_mode      = prog_mode_q;
  assign addr_select    = addr_select_q;
  assign bus_enable_n   = bus_en_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule
